issue_queue: RTL

- Synchronous FIFO that buffers decoded instruction packets between the frontend decoder (writer) and the backend instruction issuer (reader).
- Read side is show-ahead: the head entry is always presented on issue_q_rdata, qualified by issue_q_rok, and popped by issue_q_ren.
- A synchronous flush empties the queue on branch mispredict or redirect.

---
 rtl/issue_queue_if.sv | 27 ++
 rtl/issue_queue.sv | 75 +++++++
 2 files changed

// File: rtl/issue_queue_if.sv
// Decoder/issuer handshake bundle for the issue queue.
// master = decoder + issuer side, slave = queue.
interface issue_queue_if #(
  parameter int unsigned ISSUE_Q_WIDTH = 123,
  parameter int unsigned ISSUE_Q_DEPTH = 4
);
  localparam int unsigned CW = $clog2(ISSUE_Q_DEPTH) + 1;

  logic                     issue_q_flush;
  logic                     issue_q_wen;
  logic                     issue_q_wok;
  logic [ISSUE_Q_WIDTH-1:0] issue_q_wdata;
  logic                     issue_q_ren;
  logic                     issue_q_rok;
  logic [ISSUE_Q_WIDTH-1:0] issue_q_rdata;
  logic [CW-1:0]            issue_q_count;

  modport master (
    output issue_q_flush, issue_q_wen, issue_q_wdata, issue_q_ren,
    input  issue_q_wok, issue_q_rok, issue_q_rdata, issue_q_count
  );

  modport slave (
    input  issue_q_flush, issue_q_wen, issue_q_wdata, issue_q_ren,
    output issue_q_wok, issue_q_rok, issue_q_rdata, issue_q_count
  );
endinterface

// File: rtl/issue_queue.sv
// Show-ahead FIFO between decoder and issuer, with synchronous flush.
// Optional ISSUE_Q_BYPASS_EN: same-cycle write-to-read pass-through when empty.
module issue_queue #(
  parameter int unsigned ISSUE_Q_WIDTH      = 123,
  parameter int unsigned ISSUE_Q_DEPTH      = 4,
  parameter int unsigned ISSUE_Q_DEPTH_LOG2 = $clog2(ISSUE_Q_DEPTH)
) (
  input  logic           CLK,
  input  logic           RSTN,
  issue_queue_if.slave   q
);
  localparam int unsigned PW = ISSUE_Q_DEPTH_LOG2;
  localparam int unsigned CW = ISSUE_Q_DEPTH_LOG2 + 1;

  logic [ISSUE_Q_WIDTH-1:0] r_mem [ISSUE_Q_DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;

  logic w_empty;
  logic w_full;
  logic w_byp;
  logic w_pass;
  logic w_push;
  logic w_pop;
  logic w_wr_en;

  assign w_empty = (r_count == CW'(0));
  assign w_full  = (r_count == CW'(ISSUE_Q_DEPTH));

`ifdef ISSUE_Q_BYPASS_EN
  // Empty queue presents the incoming packet directly; a same-cycle read consumes it.
  assign w_byp  = w_empty & q.issue_q_wen;
  assign w_pass = w_byp & q.issue_q_ren;
`else
  assign w_byp  = 1'b0;
  assign w_pass = 1'b0;
`endif

  assign w_push  = q.issue_q_wen & ~w_full & ~w_pass;
  assign w_pop   = q.issue_q_ren & ~w_empty;
  assign w_wr_en = w_push & ~q.issue_q_flush;

  assign q.issue_q_wok   = ~w_full;
  assign q.issue_q_rok   = ~w_empty | w_byp;
  assign q.issue_q_count = r_count;
  assign q.issue_q_rdata = w_byp ? q.issue_q_wdata : r_mem[r_rd_ptr];

  // Storage is intentionally left unreset; rok qualifies rdata.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= q.issue_q_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (q.issue_q_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
